// File: rtl/axi_cmd_master_if.sv
// Command/completion channel plus a single-ID AXI4 master port bundled for axi_cmd_master.
interface axi_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  logic                    cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic                    rsp_valid, rsp_ready, rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  logic [ID_WIDTH-1:0]     m_axi_awid;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awlock;
  logic [3:0]              m_axi_awcache;
  logic [2:0]              m_axi_awprot;
  logic                    m_axi_awvalid, m_axi_awready;

  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast, m_axi_wvalid, m_axi_wready;

  logic [ID_WIDTH-1:0]     m_axi_bid;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid, m_axi_bready;

  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arlock;
  logic [3:0]              m_axi_arcache;
  logic [2:0]              m_axi_arprot;
  logic                    m_axi_arvalid, m_axi_arready;

  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast, m_axi_rvalid, m_axi_rready;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_cmd_master.sv
// Single-outstanding command-to-AXI4 bridge: one single-beat read or write per command,
// completion returned on rsp_*. All non-constant outputs come straight from flops.
module axi_cmd_master #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0,
  parameter bit                  WAIT_BRESP = 1'b0
) (
  input logic              aclk,
  input logic              areset,
  axi_cmd_master_if.master bus
);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                  bready_q, bready_d, rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  unused_bits;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        // cmd_ready rises one edge after reset release or after a completion
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
          if (bus.cmd_wr) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      WR_REQ: begin
        if (bus.m_axi_awready) awvalid_d = 1'b0;
        if (bus.m_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          if (WAIT_BRESP) begin
            state_d  = WR_RESP;
            bready_d = 1'b1;
          end else begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
          end
        end
      end
      WR_RESP: begin
        if (bus.m_axi_bvalid) begin
          bready_d    = 1'b0;
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.m_axi_bresp[1] | (bus.m_axi_bid != AXI_ID);
        end
      end
      RD_REQ: begin
        if (bus.m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (bus.m_axi_rvalid) begin
          rready_d    = 1'b0;
          rdata_d     = bus.m_axi_rdata;
          rsp_err_d   = bus.m_axi_rresp[1] | (bus.m_axi_rid != AXI_ID);
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_rdata     = rdata_q;

  assign bus.m_axi_awid    = AXI_ID;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = 3'($clog2(STRB_W));
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'd0;
  assign bus.m_axi_awprot  = 3'd0;
  assign bus.m_axi_awvalid = awvalid_q;

  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = {STRB_W{1'b1}};
  assign bus.m_axi_wlast   = 1'b1;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;

  assign bus.m_axi_arid    = AXI_ID;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = 3'($clog2(STRB_W));
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'd0;
  assign bus.m_axi_arprot  = 3'd0;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;

  // Single-beat reads: rlast carries no information; only the error bit of each resp matters
  assign unused_bits = ^{bus.m_axi_rlast, bus.m_axi_bresp[0], bus.m_axi_rresp[0]};
endmodule
